// File: rtl/lsu_ctrl.sv
// Load/store unit: decodes memi, drives the data-memory handshake,
// aligns and extends load data, and stalls the core until completion.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  memi,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        ld_q;

  logic        is_ld;
  logic        is_st;
  logic        valid;
  logic [2:0]  f3;
  logic        legal;
  logic        misal;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;

  assign is_ld = memi[4] & ~memi[3];
  assign is_st = memi[3] & ~memi[4];
  assign valid = is_ld | is_st;
  assign f3    = memi[2:0];

  assign sz_b = (f3[1:0] == 2'b00);
  assign sz_h = (f3[1:0] == 2'b01);
  assign sz_w = (f3[1:0] == 2'b10);

  always_comb begin
    legal = 1'b0;
    if (is_ld)
      legal = (f3 == 3'b000) || (f3 == 3'b001) ||
              (f3 == 3'b010) || (f3 == 3'b100) ||
              (f3 == 3'b101);
    else if (is_st)
      legal = (f3 == 3'b000) || (f3 == 3'b001) ||
              (f3 == 3'b010);
  end

  assign misal = (sz_h & addr_i[0]) |
                 (sz_w & (addr_i[1:0] != 2'b00));

  always_comb begin
    be_n = 4'b0000;
    wd_n = 32'h0;
    unique case (1'b1)
      sz_b: begin
        be_n = 4'b0001 << addr_i[1:0];
        wd_n = {4{wdata_i[7:0]}};
      end
      sz_h: begin
        be_n = 4'b0011 << {addr_i[1], 1'b0};
        wd_n = {2{wdata_i[15:0]}};
      end
      sz_w: begin
        be_n = 4'b1111;
        wd_n = wdata_i;
      end
      default: ;
    endcase
  end

  // Lane select uses the address latched at issue, not the live one.
  assign lb = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign lh = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ext = mem_rdata_i;
    unique case (f3_q)
      3'b000:  ext = {{24{lb[7]}}, lb};
      3'b001:  ext = {{16{lh[15]}}, lh};
      3'b100:  ext = {24'h0, lb};
      3'b101:  ext = {16'h0, lh};
      default: ext = mem_rdata_i;
    endcase
  end

  assign stall_o    = ((state == IDLE) & valid) | (state == REQ);
  assign mem_addr_o = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'h0;
      addr_q      <= 32'h0;
      f3_q        <= 3'b000;
      ld_q        <= 1'b0;
      rdata_o     <= 32'h0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= 32'h0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            addr_q      <= addr_i;
            f3_q        <= f3;
            ld_q        <= is_ld;
            mem_be_o    <= be_n;
            mem_wdata_o <= wd_n;
            cnt         <= 8'h0;
            if (legal && !misal) begin
              state     <= REQ;
              mem_req_o <= 1'b1;
              mem_we_o  <= is_st;
            end else begin
              state      <= ERR;
              misalign_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            done_o    <= 1'b1;
            if (ld_q)
              rdata_o <= ext;
          end else if (cnt == TMO) begin
            state     <= ERR;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
